// File: rtl/systolic_array_sequencer_if.sv
// Host command / array datapath / result drain signal bundle for systolic_array_sequencer.
// master = sequencer side, slave = host + datapath side.
interface systolic_array_sequencer_if #(
  parameter int N       = 4,
  parameter int K_WIDTH = 8
);
  logic                   start;
  logic [K_WIDTH-1:0]     kLen;
  logic                   busy;
  logic                   clearAcc;
  logic                   feedValid;
  logic [K_WIDTH-1:0]     feedK;
  logic [N-1:0]           rowEn;
  logic [N-1:0]           colEn;
  logic                   resultValid;
  logic [$clog2(N)-1:0]   resultRow;
  logic                   resultReady;
  logic                   done;

  modport master (
    input  start, kLen, resultReady,
    output busy, clearAcc, feedValid, feedK, rowEn, colEn, resultValid, resultRow, done
  );

  modport slave (
    output start, kLen, resultReady,
    input  busy, clearAcc, feedValid, feedK, rowEn, colEn, resultValid, resultRow, done
  );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Control FSM for one NxN systolic matrix-multiply pass: clear, skewed compute wavefront, row drain.
// Optional SEQ_PERF_CNT_EN adds saturating busy/stall cycle counters.
module systolic_array_sequencer #(
  parameter int N         = 4,
  parameter int K_WIDTH   = 8,
  parameter int CNT_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rstN,
  systolic_array_sequencer_if.master   bus
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                  perfBusyCycles,
  output logic [31:0]                  perfStallCycles
`endif
);
  localparam int RW = $clog2(N);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] COMPUTE = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] c_q, c_d;
  logic [RW-1:0]        r_q, r_d;
  logic [K_WIDTH-1:0]   k_q, k_d;

  logic                 busy_q, busy_d;
  logic                 clear_acc_q, clear_acc_d;
  logic                 feed_valid_q, feed_valid_d;
  logic [K_WIDTH-1:0]   feed_k_q, feed_k_d;
  logic [N-1:0]         en_q, en_d;
  logic                 result_valid_q, result_valid_d;
  logic [RW-1:0]        result_row_q, result_row_d;
  logic                 done_q, done_d;

  logic [CNT_WIDTH-1:0] k_ext;
  logic [CNT_WIDTH-1:0] last_c;

  assign k_ext  = CNT_WIDTH'(k_q);
  assign last_c = k_ext + CNT_WIDTH'(2 * N - 3);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_d     = bus.kLen;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        c_d     = '0;
        r_d     = '0;
        state_d = (k_q == '0) ? DRAIN : COMPUTE;
      end
      COMPUTE: begin
        if (c_q == last_c) begin
          c_d     = '0;
          r_d     = '0;
          state_d = DRAIN;
        end else begin
          c_d = c_q + CNT_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (bus.resultReady) begin
          if (r_q == RW'(N - 1)) state_d = DONE;
          else                   r_d     = r_q + RW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state/counter so the registered copies line up with c_q.
  always_comb begin
    busy_d         = (state_d != IDLE);
    clear_acc_d    = (state_d == CLEAR);
    result_valid_d = (state_d == DRAIN);
    result_row_d   = (state_d == DRAIN) ? r_d : '0;
    done_d         = (state_d == DONE);
    feed_valid_d   = (state_d == COMPUTE) && (c_d < k_ext);
    feed_k_d       = feed_valid_d ? c_d[K_WIDTH-1:0] : '0;
    en_d           = '0;
    for (int unsigned i = 0; i < N; i++) begin
      en_d[i] = (state_d == COMPUTE) && (c_d >= CNT_WIDTH'(i)) && (c_d < CNT_WIDTH'(i) + k_ext);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q        <= IDLE;
      c_q            <= '0;
      r_q            <= '0;
      k_q            <= '0;
      busy_q         <= 1'b0;
      clear_acc_q    <= 1'b0;
      feed_valid_q   <= 1'b0;
      feed_k_q       <= '0;
      en_q           <= '0;
      result_valid_q <= 1'b0;
      result_row_q   <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      c_q            <= c_d;
      r_q            <= r_d;
      k_q            <= k_d;
      busy_q         <= busy_d;
      clear_acc_q    <= clear_acc_d;
      feed_valid_q   <= feed_valid_d;
      feed_k_q       <= feed_k_d;
      en_q           <= en_d;
      result_valid_q <= result_valid_d;
      result_row_q   <= result_row_d;
      done_q         <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.clearAcc    = clear_acc_q;
  assign bus.feedValid   = feed_valid_q;
  assign bus.feedK       = feed_k_q;
  assign bus.rowEn       = en_q;
  assign bus.colEn       = en_q;
  assign bus.resultValid = result_valid_q;
  assign bus.resultRow   = result_row_q;
  assign bus.done        = done_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (busy_q && (perf_busy_q != '1))
      perf_busy_d = perf_busy_q + 32'd1;
    if ((state_q == DRAIN) && !bus.resultReady && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perfBusyCycles  = perf_busy_q;
  assign perfStallCycles = perf_stall_q;
`endif
endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Self-checking bench for systolic_array_sequencer: table of passes plus a mid-pass reset sequence.
module tb_systolic_array_sequencer;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int CW = 10;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  systolic_array_sequencer_if #(.N(N), .K_WIDTH(KW)) bus ();

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_stall;
`endif

  systolic_array_sequencer #(.N(N), .K_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perfBusyCycles  (perf_busy),
    .perfStallCycles (perf_stall)
`endif
  );

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];

  typedef struct {
    logic [KW-1:0] k;
    int            stall_row;       // N means no stall
    int            stall_len;
    bit            start_in_drain;
    int            exp_compute;     // expected COMPUTE length in cycles
  } pass_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_clear"}, 32'(bus.clearAcc), 0);
    check({tag, "_fv"},    32'(bus.feedValid), 0);
    check({tag, "_fk"},    32'(bus.feedK), 0);
    check({tag, "_row"},   32'(bus.rowEn), 0);
    check({tag, "_col"},   32'(bus.colEn), 0);
    check({tag, "_rv"},    32'(bus.resultValid), 0);
    check({tag, "_rr"},    32'(bus.resultRow), 0);
    check({tag, "_done"},  32'(bus.done), 0);
  endtask

  task automatic run_pass(input pass_t p);
    logic [N-1:0] er;
    int stalled;
    int budget;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] busy0, stall0;
    busy0  = perf_busy;
    stall0 = perf_stall;
`endif
    @(negedge clk);
    bus.start = 1'b1;
    bus.kLen  = p.k;
    @(negedge clk);
    bus.start = 1'b0;
    bus.kLen  = ~p.k;
    for (int r = 0; r < N; r++) exp_q.push_back(r);
    check("clear_pulse", 32'(bus.clearAcc), 1);
    check("busy_clear",  32'(bus.busy), 1);
    check("rv_clear",    32'(bus.resultValid), 0);

    for (int c = 0; c < p.exp_compute; c++) begin
      @(negedge clk);
      er = '0;
      for (int i = 0; i < N; i++) er[i] = (c >= i) && (c < i + int'(p.k));
      check("feed_valid", 32'(bus.feedValid), (c < int'(p.k)) ? 1 : 0);
      check("feed_k",     32'(bus.feedK), (c < int'(p.k)) ? c : 0);
      check("row_en",     32'(bus.rowEn), 32'(er));
      check("col_en",     32'(bus.colEn), 32'(er));
      check("clear_off",  32'(bus.clearAcc), 0);
      check("rv_compute", 32'(bus.resultValid), 0);
      check("busy_comp",  32'(bus.busy), 1);
    end

    stalled = 0;
    budget  = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      @(negedge clk);
      budget++;
      check("rv_drain",   32'(bus.resultValid), 1);
      check("done_early", 32'(bus.done), 0);
      check("en_drain",   32'(bus.rowEn), 0);
      bus.start = p.start_in_drain && (budget == 2);
      if (exp_q[0] == p.stall_row && stalled < p.stall_len) begin
        bus.resultReady = 1'b0;
        stalled++;
        check("row_hold", 32'(bus.resultRow), 32'(p.stall_row));
      end else begin
        bus.resultReady = 1'b1;
        check("result_row", 32'(bus.resultRow), 32'(exp_q.pop_front()));
      end
    end
    check("drain_timeout", 32'(exp_q.size()), 0);
    exp_q.delete();

    @(negedge clk);
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 1);
    check("busy_done",  32'(bus.busy), 1);
    check("rv_done",    32'(bus.resultValid), 0);
    @(negedge clk);
    check("done_clr",   32'(bus.done), 0);
    check("busy_fall",  32'(bus.busy), 0);
    @(negedge clk);
    check("no_queued_start", 32'(bus.clearAcc), 0);
    check("idle_busy",       32'(bus.busy), 0);
`ifdef SEQ_PERF_CNT_EN
    check("perf_stall", perf_stall - stall0, 32'(p.stall_len));
    check("perf_busy",  perf_busy - busy0, 32'(2 + p.exp_compute + N + p.stall_len));
`endif
  endtask

  pass_t table_v[5];

  initial begin
    table_v[0] = '{k: 8'd3, stall_row: N, stall_len: 0, start_in_drain: 1'b0, exp_compute: 9};
    table_v[1] = '{k: 8'd3, stall_row: 1, stall_len: 5, start_in_drain: 1'b0, exp_compute: 9};
    table_v[2] = '{k: 8'd0, stall_row: N, stall_len: 0, start_in_drain: 1'b1, exp_compute: 0};
    table_v[3] = '{k: 8'd1, stall_row: 0, stall_len: 2, start_in_drain: 1'b0, exp_compute: 7};
    table_v[4] = '{k: 8'd5, stall_row: 3, stall_len: 1, start_in_drain: 1'b0, exp_compute: 11};

    bus.start       = 1'b0;
    bus.kLen        = '0;
    bus.resultReady = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    for (int t = 0; t < 5; t++) run_pass(table_v[t]);

    // Reset mid-COMPUTE at c=4 with K=3.
    @(negedge clk);
    bus.start = 1'b1;
    bus.kLen  = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_row", 32'(bus.rowEn), 32'h0000_000C);
    check("pre_rst_fv",  32'(bus.feedValid), 0);
    check("pre_rst_busy", 32'(bus.busy), 1);
    #1 rstN = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    check("rst_no_done", 32'(bus.done), 0);
    rstN = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 0);
    run_pass('{k: 8'd2, stall_row: N, stall_len: 0, start_in_drain: 1'b0, exp_compute: 8});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/systolic_array_sequencer.md
Name: systolic_array_sequencer

Overview:
Control FSM that runs one matrix-multiply pass on the NxN systolic array.
- Clears the PE accumulators.
- Issues skewed row/column stage enables for the wavefront, so the edge master-slave register stages only advance while valid data flows.
- Drains results row by row over a valid/ready handshake.
- Sits between the host command interface and the array datapath.

Parameters:
N, 4, array dimension (rows = columns); N >= 2
K_WIDTH, 8, width of the inner-dimension length input; max K = 2^K_WIDTH-1
CNT_WIDTH, 10, internal cycle counter width; must hold K_max+2N-2

Ports:
clk  input  1  system clock, rising-edge
rstN  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
kLen  input  K_WIDTH  inner dimension K; latched when start is accepted
busy  output  1  high from the cycle after start is accepted until done
clearAcc  output  1  one-cycle pulse that zeroes all PE accumulators
feedValid  output  1  operand edge feeders present element k this cycle
feedK  output  K_WIDTH  index k of the operand column/row being fed
rowEn  output  N  per-row stage enable for the A-operand skew registers
colEn  output  N  per-column stage enable for the B-operand skew registers
resultValid  output  1  result row resultRow is available
resultRow  output  $clog2(N)  index of the PE row being drained
resultReady  input  1  downstream accepts the result row
done  output  1  one-cycle pulse after the last result handshake

Behaviour:
- Reset: rstN low forces IDLE asynchronously. All outputs, the cycle counter c, the row counter r and the latched K go to 0. Reset is legal mid-pass and abandons the pass with no done pulse.
- States: IDLE -> CLEAR -> COMPUTE -> DRAIN -> DONE -> IDLE.
- IDLE: busy=0. start=1 latches K=kLen, moves to CLEAR. start in any other state is ignored and not queued.
- CLEAR: 1 cycle with clearAcc=1, busy=1, c<=0.
  - K=0: next state is DRAIN; COMPUTE is skipped and results are zero.
  - Otherwise: next state is COMPUTE.
- COMPUTE: lasts exactly K+2N-2 cycles, c = 0..K+2N-3.
  - feedValid = (c < K); feedK = c when feedValid, else 0.
  - rowEn[i] = (c >= i) && (c < i+K); colEn[j] uses the same rule with j.
  - At c = K+2N-3: go to DRAIN, r<=0.
- DRAIN: resultValid=1, resultRow=r.
  - r advances only on resultValid && resultReady.
  - resultReady low holds r and resultValid with no timeout.
  - Handshake with r=N-1 goes to DONE.
- DONE: 1 cycle, done=1, busy=1; next cycle IDLE with busy=0. The earliest start of a new pass is the cycle after DONE.
- Outputs rowEn, colEn, feedValid and feedK are registered, giving zero cycles of skew relative to c as defined above. clearAcc, resultValid and done are registered from state.
- Counter arithmetic is unsigned. The K+2N-2 comparison is performed at CNT_WIDTH without overflow, which requires CNT_WIDTH >= bits(K_max+2N-2).

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: adds outputs perfBusyCycles (32) and perfStallCycles (32).
  - perfBusyCycles counts cycles with busy=1.
  - perfStallCycles counts DRAIN cycles with resultReady=0.
  - Both saturate at 2^32-1 and clear only on rstN.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then N=4, start with kLen=3 -> clearAcc pulse 1 cycle after start, then COMPUTE of exactly 9 cycles; feedValid high on c=0..2 with feedK=0,1,2.
- Same pass, checking enables -> rowEn[0] high on c=0..2, rowEn[3] high on c=3..5, colEn identical, all enables 0 on c=6..8.
- DRAIN with resultReady tied 1 -> resultRow 0,1,2,3 on 4 consecutive cycles, done pulses once, busy falls the next cycle.
- Backpressure: resultReady=0 for 5 cycles at r=1 -> resultRow holds 1, no done. With SEQ_PERF_CNT_EN, perfStallCycles += 5.
- kLen=0 -> CLEAR goes directly to DRAIN with no rowEn/colEn/feedValid activity; 4 result rows, then done. start pulsed during DRAIN is ignored.
- Drop rstN during COMPUTE at c=4 -> all outputs 0 immediately, no done; a new start with kLen=2 runs a clean 8-cycle COMPUTE.
